mem_access_ctrl: RTL and testbench

//   Memory-side sequencer between the datapath MAR/MDR pair and a single-port word RAM.

---
 rtl/mem_access_ctrl_if.sv | 59 +++++
 rtl/mem_access_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl.
// The control-unit handshake (req/busy/done), the MAR/MDR data paths and the
// RAM port are grouped here. The controller uses the slave modport. The
// environment (control unit, datapath and RAM) uses the master modport.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 9
);
    // Control unit / datapath side
    logic              req_read;
    logic              req_write;
    logic [31:0]       MARout;
    logic [31:0]       MDRout;
    logic [31:0]       Mdatain;
    logic              mdr_load;
    logic              busy;
    logic              done;
    logic              err;

    // RAM side
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_en;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_read,
        input  req_write,
        input  MARout,
        input  MDRout,
        input  mem_rdata,
        output Mdatain,
        output mdr_load,
        output busy,
        output done,
        output err,
        output mem_addr,
        output mem_wdata,
        output mem_en,
        output mem_we
    );

    modport master (
        output req_read,
        output req_write,
        output MARout,
        output MDRout,
        output mem_rdata,
        input  Mdatain,
        input  mdr_load,
        input  busy,
        input  done,
        input  err,
        input  mem_addr,
        input  mem_wdata,
        input  mem_en,
        input  mem_we
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequencer between the MAR/MDR pair and a single-port word RAM.
// A one-cycle read or write request taken in IDLE drives the RAM for
// WAIT_CYCLES+1 cycles. A one-cycle done pulse follows. Reads also produce an
// MDR load strobe, and the data is captured on Mdatain.
// All outputs come straight from flops.
// Optional feature: define MEM_ACCESS_ERR_EN to reject addresses >= MEM_DEPTH.
// A rejected access skips the RAM and reports err with done.
module mem_access_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_DEPTH   = 512
) (
    input  logic               clock,
    input  logic               clear_n,
    mem_access_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

    state_t            state_q,    state_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic              op_rd_q,    op_rd_d;
    logic [31:0]       mdatain_q,  mdatain_d;
    logic              mdr_load_q, mdr_load_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              en_q,       en_d;
    logic              we_q,       we_d;
    logic              req_s;
    logic              range_err_s;

    // The address bits above ADDR_W never reach the RAM. MEM_DEPTH only
    // matters when the range check is built in. Both are folded into this
    // unused bit.
    logic              unused_bits_s;
    assign unused_bits_s = ^{bus.MARout[31:ADDR_W], 32'(MEM_DEPTH)};

    assign req_s = bus.req_read | bus.req_write;

`ifdef MEM_ACCESS_ERR_EN
    localparam logic [31:0] DEPTH_C = 32'(MEM_DEPTH);

    logic err_q, err_d;

    // Range check on the full 32-bit MAR value at accept time.
    always_comb begin
        range_err_s = (bus.MARout >= DEPTH_C);
    end
`else
    // Without the range check, every address is valid and is truncated.
    always_comb begin
        range_err_s = 1'b0;
    end
`endif

    // Next-state and registered-output logic for the IDLE/ACCESS/DONE sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_rd_d    = op_rd_q;
        mdatain_d  = mdatain_q;
        mdr_load_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        en_d       = en_q;
        we_d       = we_q;
`ifdef MEM_ACCESS_ERR_EN
        err_d      = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    // Read wins when both requests are high together.
                    op_rd_d = bus.req_read;
                    addr_d  = bus.MARout[ADDR_W-1:0];
                    wdata_d = bus.MDRout;
                    cnt_d   = WAIT_C;
                    busy_d  = 1'b1;
                    if (range_err_s) begin
                        // The RAM is never touched. Report the fault from DONE.
                        en_d    = 1'b0;
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        en_d    = 1'b1;
                        we_d    = ~bus.req_read;
                        state_d = ST_ACCESS;
                    end
`ifdef MEM_ACCESS_ERR_EN
                    err_d = range_err_s;
`endif
                end else begin
                    busy_d = 1'b0;
                    en_d   = 1'b0;
                    we_d   = 1'b0;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // In the final ACCESS cycle, RAM read data is valid.
                    if (op_rd_q) begin
                        mdatain_d = bus.mem_rdata;
                    end else begin
                        mdatain_d = mdatain_q;
                    end
                    mdr_load_d = op_rd_q;
                    done_d     = 1'b1;
                    en_d       = 1'b0;
                    we_d       = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                en_d    = 1'b0;
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything, which aborts any RAM cycle.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            op_rd_q    <= 1'b0;
            mdatain_q  <= 32'd0;
            mdr_load_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_rd_q    <= op_rd_d;
            mdatain_q  <= mdatain_d;
            mdr_load_q <= mdr_load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            en_q       <= en_d;
            we_q       <= we_d;
        end
    end

`ifdef MEM_ACCESS_ERR_EN
    // The fault flag stays up until the next accepted request or a reset.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.Mdatain   = mdatain_q;
    assign bus.mdr_load  = mdr_load_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with WAIT_CYCLES=2.
// The RAM model has a combinational read. A write commits only after
// WAIT_CYCLES+1 consecutive enabled write cycles, so a write that a reset
// cuts short leaves the word untouched.
module tb_mem_access_ctrl;

    localparam int WAITC = 2;

    logic clk;
    logic clear_n;
    int   checks;
    int   errors;
    int   wcnt;

    logic [31:0] ram [0:511];

    mem_access_ctrl_if #(.ADDR_W(9)) bus ();

    mem_access_ctrl #(
        .ADDR_W      (9),
        .WAIT_CYCLES (WAITC),
        .MEM_DEPTH   (512)
    ) dut (
        .clock   (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = ram[bus.mem_addr];

    // RAM write commits at the end of a full-length write access.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            if (wcnt == WAITC) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // Starts at a negedge, drives one request and observes until the cycle after done.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic pulse,
                              output int en_cnt, output int we_cnt, output int done_cnt,
                              output int ld_cnt, output int done_at,
                              output logic [8:0] addr_seen, output logic [31:0] wdata_seen,
                              output logic err_first, output logic err_at_done,
                              output logic busy_after);
        en_cnt = 0; we_cnt = 0; done_cnt = 0; ld_cnt = 0; done_at = -1;
        addr_seen = 9'd0; wdata_seen = 32'd0; err_first = 1'b0; err_at_done = 1'b0;
        busy_after = 1'b1;
        bus.req_read  = rd;
        bus.req_write = wr;
        bus.MARout    = addr;
        bus.MDRout    = wdata;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.req_read  = 1'b0;
                bus.req_write = 1'b0;
                addr_seen  = bus.mem_addr;
                wdata_seen = bus.mem_wdata;
                err_first  = bus.err;
            end
            if (bus.mem_en)   en_cnt++;
            if (bus.mem_we)   we_cnt++;
            if (bus.mdr_load) ld_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at     = i;
                    err_at_done = bus.err;
                end
            end
            if (done_at >= 0 && i == done_at + 1) begin
                busy_after    = bus.busy;
                bus.req_write = 1'b0;
                break;
            end
            if (pulse && i >= 2) bus.req_write = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        bus.req_read = 1'b1; bus.req_write = 1'b0;
        bus.MARout = 32'h10; bus.MDRout = 32'h5A5A5A5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.Mdatain, bus.mdr_load, bus.busy, bus.done, bus.err, bus.mem_addr,
             bus.mem_wdata, bus.mem_en, bus.mem_we} !== 77'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b en=%b Mdatain=%h expected all zero",
                     bus.busy, bus.mem_en, bus.Mdatain);
        end
        bus.req_read = 1'b0;
        clear_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.mem_en, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got busy/en/done=%b%b%b expected 000",
                     bus.busy, bus.mem_en, bus.done);
        end
    endtask

    task automatic test_read();
        int en, we, dn, ld, at; logic [8:0] a; logic [31:0] w; logic e1, ed, ba;
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, en, we, dn, ld, at, a, w, e1, ed, ba);
        checks++; if (en !== 3) begin errors++; $display("FAIL rd_en_cycles: got %0d expected 3", en); end
        checks++; if (we !== 0) begin errors++; $display("FAIL rd_we_cycles: got %0d expected 0", we); end
        checks++; if (at !== 4) begin errors++; $display("FAIL rd_done_cycle: got %0d expected 4", at); end
        checks++; if (dn !== 1 || ld !== 1) begin errors++; $display("FAIL rd_pulses: got done=%0d load=%0d expected 1 1", dn, ld); end
        checks++; if (bus.Mdatain !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", bus.Mdatain); end
        checks++; if (a !== 9'h010) begin errors++; $display("FAIL rd_addr: got %h expected 010", a); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL rd_busy_after: got %b expected 0", ba); end
    endtask

    task automatic test_write();
        int en, we, dn, ld, at; logic [8:0] a; logic [31:0] w; logic e1, ed, ba;
        run_access(1'b0, 1'b1, 32'h1F, 32'h12345678, 1'b0, en, we, dn, ld, at, a, w, e1, ed, ba);
        checks++; if (we !== 3 || en !== 3) begin errors++; $display("FAIL wr_we_cycles: got we=%0d en=%0d expected 3 3", we, en); end
        checks++; if (dn !== 1 || ld !== 0) begin errors++; $display("FAIL wr_pulses: got done=%0d load=%0d expected 1 0", dn, ld); end
        checks++; if (at !== 4) begin errors++; $display("FAIL wr_done_cycle: got %0d expected 4", at); end
        checks++; if (ram[9'h1F] !== 32'h12345678) begin errors++; $display("FAIL wr_ram: got %h expected 12345678", ram[9'h1F]); end
        checks++; if (w !== 32'h12345678) begin errors++; $display("FAIL wr_wdata: got %h expected 12345678", w); end
        checks++; if (bus.Mdatain !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mdatain_hold: got %h expected deadbeef", bus.Mdatain); end
    endtask

    task automatic test_simultaneous();
        int en, we, dn, ld, at, extra; logic [8:0] a; logic [31:0] w; logic e1, ed, ba;
        run_access(1'b1, 1'b1, 32'h1F, 32'hAAAA5555, 1'b1, en, we, dn, ld, at, a, w, e1, ed, ba);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.mem_en) extra++;
        end
        checks++; if (we !== 0) begin errors++; $display("FAIL both_is_read: got we=%0d expected 0", we); end
        checks++; if (dn !== 1 || ld !== 1) begin errors++; $display("FAIL both_pulses: got done=%0d load=%0d expected 1 1", dn, ld); end
        checks++; if (bus.Mdatain !== 32'h12345678) begin errors++; $display("FAIL both_data: got %h expected 12345678", bus.Mdatain); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_req_dropped: got %0d active cycles expected 0", extra); end
        checks++; if (ram[9'h1F] !== 32'h12345678) begin errors++; $display("FAIL busy_write_ignored: got %h expected 12345678", ram[9'h1F]); end
    endtask

`ifdef MEM_ACCESS_ERR_EN
    task automatic test_range_error();
        int en, we, dn, ld, at; logic [8:0] a; logic [31:0] w; logic e1, ed, ba;
        run_access(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, en, we, dn, ld, at, a, w, e1, ed, ba);
        checks++; if (en !== 0) begin errors++; $display("FAIL err_no_en: got %0d expected 0", en); end
        checks++; if (at !== 1 || ed !== 1'b1) begin errors++; $display("FAIL err_done: got at=%0d err=%b expected 1 1", at, ed); end
        checks++; if (ld !== 0) begin errors++; $display("FAIL err_no_load: got %0d expected 0", ld); end
        checks++; if (bus.Mdatain !== 32'h12345678 || bus.err !== 1'b1) begin errors++; $display("FAIL err_hold: got Mdatain=%h err=%b expected 12345678 1", bus.Mdatain, bus.err); end
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, en, we, dn, ld, at, a, w, e1, ed, ba);
        checks++; if (e1 !== 1'b0 || ed !== 1'b0) begin errors++; $display("FAIL err_clear: got %b %b expected 0 0", e1, ed); end
    endtask
`else
    task automatic test_truncation();
        int en, we, dn, ld, at; logic [8:0] a; logic [31:0] w; logic e1, ed, ba;
        run_access(1'b1, 1'b0, 32'h0000_0210, 32'h0, 1'b0, en, we, dn, ld, at, a, w, e1, ed, ba);
        checks++; if (a !== 9'h010) begin errors++; $display("FAIL trunc_addr: got %h expected 010", a); end
        checks++; if (bus.Mdatain !== 32'hDEADBEEF) begin errors++; $display("FAIL trunc_data: got %h expected deadbeef", bus.Mdatain); end
        checks++; if (ed !== 1'b0 || at !== 4) begin errors++; $display("FAIL trunc_no_err: got err=%b at=%0d expected 0 4", ed, at); end
    endtask
`endif

    task automatic test_abort();
        int dn;
        bus.req_write = 1'b1; bus.MARout = 32'h30; bus.MDRout = 32'hCAFEF00D;
        @(negedge clk);
        bus.req_write = 1'b0;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL abort_started: got we=%b expected 1", bus.mem_we); end
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.busy, bus.done, bus.mem_addr, bus.mem_wdata, bus.Mdatain} !== 77'd0) begin
            errors++;
            $display("FAIL abort_async_clear: got en=%b we=%b busy=%b Mdatain=%h expected all zero",
                     bus.mem_en, bus.mem_we, bus.busy, bus.Mdatain);
        end
        dn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dn); end
        checks++; if (ram[9'h30] !== 32'h11111111) begin errors++; $display("FAIL abort_ram_kept: got %h expected 11111111", ram[9'h30]); end
    endtask

    task automatic test_back_to_back();
        int en, we, dn, ld, at; logic [8:0] a; logic [31:0] w; logic e1, ed, ba;
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, en, we, dn, ld, at, a, w, e1, ed, ba);
        checks++; if (bus.Mdatain !== 32'hDEADBEEF || at !== 4) begin errors++; $display("FAIL b2b_first: got %h at=%0d expected deadbeef 4", bus.Mdatain, at); end
        run_access(1'b1, 1'b0, 32'h1F, 32'h0, 1'b0, en, we, dn, ld, at, a, w, e1, ed, ba);
        checks++; if (at !== 4 || en !== 3) begin errors++; $display("FAIL b2b_second_timing: got at=%0d en=%0d expected 4 3", at, en); end
        checks++; if (bus.Mdatain !== 32'h12345678) begin errors++; $display("FAIL b2b_second_data: got %h expected 12345678", bus.Mdatain); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wcnt   = 0;
        for (int i = 0; i < 512; i++) ram[i] = 32'd0;
        ram[9'h10] = 32'hDEADBEEF;
        ram[9'h30] = 32'h11111111;
        clear_n = 1'b0;
        bus.req_read = 1'b0; bus.req_write = 1'b0;
        bus.MARout = 32'd0; bus.MDRout = 32'd0;

        test_reset();
        test_read();
        test_write();
        test_simultaneous();
`ifdef MEM_ACCESS_ERR_EN
        test_range_error();
`else
        test_truncation();
`endif
        test_abort();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
